// File: rtl/sf_camera_pixel_reader.sv
// Camera receive path: synchronises sensor pins to clk, pairs bytes into RGB565
// pixels and streams them through a small valid/ready FIFO with frame/line status.
module sf_camera_pixel_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic                 i_clear,
  input  logic                 i_cam_pclk,
  input  logic                 i_cam_vsync,
  input  logic                 i_cam_href,
  input  logic [7:0]           i_cam_data,
  output logic [15:0]          o_pixel_data,
  output logic                 o_pixel_valid,
  input  logic                 i_pixel_ready,
  output logic                 o_frame_start,
  output logic                 o_frame_done,
  output logic [CNT_WIDTH-1:0] o_line_count,
  output logic [CNT_WIDTH-1:0] o_line_width,
  output logic                 o_overflow,
  output logic                 o_byte_error,
  output logic                 o_busy
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Two-flop synchronisers plus a third copy for edge detection
  logic       pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic       vsync_s1_q, vsync_s2_q, vsync_s3_q;
  logic       href_s1_q, href_s2_q, href_s3_q;
  logic [7:0] data_s1_q, data_s2_q;

  // Registered edge events
  logic       samp_q, href_q, href_rise_q, href_fall_q, vsync_rise_q;
  logic [7:0] byte_q;

  // Pairing / FSM state
  logic [1:0]           state_q, state_d;
  logic                 phase_q, phase_d;
  logic [7:0]           hi_q, hi_d;
  logic                 push_q, push_d;
  logic [15:0]          pix_q, pix_d;
  logic [CNT_WIDTH-1:0] px_cnt_q, px_cnt_d;
  logic [CNT_WIDTH-1:0] line_count_q, line_count_d;
  logic [CNT_WIDTH-1:0] line_width_q, line_width_d;
  logic                 started_q, started_d;
  logic                 frame_start_q, frame_start_d;
  logic                 frame_done_q, frame_done_d;
  logic                 byte_error_q, byte_error_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;

  // FIFO state
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          fifo_full, do_push, do_pop, drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_s1_q    <= 1'b0;
      pclk_s2_q    <= 1'b0;
      pclk_s3_q    <= 1'b0;
      vsync_s1_q   <= 1'b0;
      vsync_s2_q   <= 1'b0;
      vsync_s3_q   <= 1'b0;
      href_s1_q    <= 1'b0;
      href_s2_q    <= 1'b0;
      href_s3_q    <= 1'b0;
      data_s1_q    <= 8'h00;
      data_s2_q    <= 8'h00;
      samp_q       <= 1'b0;
      href_q       <= 1'b0;
      href_rise_q  <= 1'b0;
      href_fall_q  <= 1'b0;
      vsync_rise_q <= 1'b0;
      byte_q       <= 8'h00;
    end else begin
      pclk_s1_q    <= i_cam_pclk;
      pclk_s2_q    <= pclk_s1_q;
      pclk_s3_q    <= pclk_s2_q;
      vsync_s1_q   <= i_cam_vsync;
      vsync_s2_q   <= vsync_s1_q;
      vsync_s3_q   <= vsync_s2_q;
      href_s1_q    <= i_cam_href;
      href_s2_q    <= href_s1_q;
      href_s3_q    <= href_s2_q;
      data_s1_q    <= i_cam_data;
      data_s2_q    <= data_s1_q;
      samp_q       <= pclk_s2_q & ~pclk_s3_q;
      href_q       <= href_s2_q;
      href_rise_q  <= href_s2_q & ~href_s3_q;
      href_fall_q  <= ~href_s2_q & href_s3_q;
      vsync_rise_q <= vsync_s2_q & ~vsync_s3_q;
      byte_q       <= data_s2_q;
    end
  end

  // Frame FSM, byte pairing and line bookkeeping
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    push_d        = 1'b0;
    pix_d         = pix_q;
    px_cnt_d      = px_cnt_q;
    line_count_d  = line_count_q;
    line_width_d  = line_width_q;
    started_d     = started_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    byte_error_d  = i_clear ? 1'b0 : byte_error_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (vsync_rise_q) begin
          state_d      = ST_FRAME;
          phase_d      = 1'b0;
          px_cnt_d     = '0;
          line_count_d = '0;
          started_d    = 1'b0;
        end
      end
      ST_FRAME: begin
        if (vsync_rise_q) begin
          frame_done_d = 1'b1;
          state_d      = i_enable ? ST_ARM : ST_IDLE;
        end else begin
          if (href_rise_q && !started_q) begin
            frame_start_d = 1'b1;
            started_d     = 1'b1;
          end
          if (href_fall_q) begin
            line_width_d = px_cnt_q;
            px_cnt_d     = '0;
            if (px_cnt_q != '0 && line_count_q != CNT_MAX)
              line_count_d = line_count_q + CNT_WIDTH'(1);
            // A dangling first byte is discarded so the next line pairs cleanly
            if (phase_q) begin
              byte_error_d = 1'b1;
              phase_d      = 1'b0;
            end
          end else if (samp_q && href_q) begin
            if (!phase_q) begin
              hi_d    = byte_q;
              phase_d = 1'b1;
            end else begin
              push_d  = 1'b1;
              pix_d   = {hi_q, byte_q};
              phase_d = 1'b0;
              if (px_cnt_q != CNT_MAX) px_cnt_d = px_cnt_q + CNT_WIDTH'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_FRAME);
  end

  // FIFO control; fullness is judged before any same-cycle pop
  always_comb begin
    fifo_full = (count_q == CW'(FIFO_DEPTH));
    do_push   = push_q & ~fifo_full;
    drop      = push_q & fifo_full;
    do_pop    = valid_q & i_pixel_ready;
    wr_ptr_d  = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (!do_push && do_pop) count_d = count_q - CW'(1);
    valid_d    = (count_d != '0);
    overflow_d = i_clear ? 1'b0 : overflow_q;
    if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      phase_q       <= 1'b0;
      hi_q          <= 8'h00;
      push_q        <= 1'b0;
      pix_q         <= 16'h0000;
      px_cnt_q      <= '0;
      line_count_q  <= '0;
      line_width_q  <= '0;
      started_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      byte_error_q  <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      push_q        <= push_d;
      pix_q         <= pix_d;
      px_cnt_q      <= px_cnt_d;
      line_count_q  <= line_count_d;
      line_width_q  <= line_width_d;
      started_q     <= started_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      byte_error_q  <= byte_error_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 16'h0000;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= pix_q;
    end
  end

  assign o_pixel_data  = mem_q[rd_ptr_q];
  assign o_pixel_valid = valid_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_done  = frame_done_q;
  assign o_line_count  = line_count_q;
  assign o_line_width  = line_width_q;
  assign o_overflow    = overflow_q;
  assign o_byte_error  = byte_error_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_sf_camera_pixel_reader.sv
// Directed bench for sf_camera_pixel_reader: drives camera pins at 1/4 clk rate
// and checks pixels, status, error flags, reset and pin-to-valid latency.
module tb_sf_camera_pixel_reader;

  logic        clk;
  logic        rst;
  logic        i_enable;
  logic        i_clear;
  logic        i_cam_pclk;
  logic        i_cam_vsync;
  logic        i_cam_href;
  logic [7:0]  i_cam_data;
  logic [15:0] o_pixel_data;
  logic        o_pixel_valid;
  logic        i_pixel_ready;
  logic        o_frame_start;
  logic        o_frame_done;
  logic [11:0] o_line_count;
  logic [11:0] o_line_width;
  logic        o_overflow;
  logic        o_byte_error;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;
  int fs_cnt   = 0;
  int fd_cnt   = 0;
  logic [15:0] pix_q[$];

  sf_camera_pixel_reader #(.FIFO_DEPTH(4), .CNT_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_clear(i_clear),
    .i_cam_pclk(i_cam_pclk), .i_cam_vsync(i_cam_vsync), .i_cam_href(i_cam_href),
    .i_cam_data(i_cam_data), .o_pixel_data(o_pixel_data), .o_pixel_valid(o_pixel_valid),
    .i_pixel_ready(i_pixel_ready), .o_frame_start(o_frame_start), .o_frame_done(o_frame_done),
    .o_line_count(o_line_count), .o_line_width(o_line_width), .o_overflow(o_overflow),
    .o_byte_error(o_byte_error), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted pixels are collected on the handshake edge
  always @(posedge clk) if (o_pixel_valid && i_pixel_ready) pix_q.push_back(o_pixel_data);

  always @(negedge clk) begin
    if (o_frame_start) fs_cnt++;
    if (o_frame_done)  fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    i_cam_data = b;
    i_cam_pclk = 1'b0;
    wait_clk(2);
    i_cam_pclk = 1'b1;
    wait_clk(2);
  endtask

  task automatic cam_line(input int nbytes, input logic [7:0] first);
    i_cam_href = 1'b1;
    i_cam_pclk = 1'b0;
    wait_clk(2);
    for (int i = 0; i < nbytes; i++) cam_byte(first + 8'(i));
    i_cam_pclk = 1'b0;
    i_cam_href = 1'b0;
    wait_clk(6);
  endtask

  task automatic vsync_pulse();
    i_cam_vsync = 1'b1;
    wait_clk(3);
    i_cam_vsync = 1'b0;
    wait_clk(6);
  endtask

  initial begin
    int fd0;
    rst = 1'b0; i_enable = 1'b0; i_clear = 1'b0; i_cam_pclk = 1'b0;
    i_cam_vsync = 1'b0; i_cam_href = 1'b0; i_cam_data = 8'h00; i_pixel_ready = 1'b1;
    wait_clk(3);
    check("rst_valid", 32'(o_pixel_valid), 32'd0);
    check("rst_line_count", 32'(o_line_count), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_byte_error", 32'(o_byte_error), 32'd0);
    rst = 1'b1;
    wait_clk(2);

    // 1: two lines of four pixels
    i_enable = 1'b1;
    wait_clk(2);
    vsync_pulse();
    check("t1_busy", 32'(o_busy), 32'd1);
    cam_line(8, 8'h01);
    cam_line(8, 8'h09);
    vsync_pulse();
    check("t1_npix", 32'(pix_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check("t1_pixel", 32'(pix_q[i]), 32'(((2 * i + 1) << 8) | (2 * i + 2)));
    check("t1_line_count", 32'(o_line_count), 32'd2);
    check("t1_line_width", 32'(o_line_width), 32'd4);
    check("t1_frame_start", 32'(fs_cnt), 32'd1);
    check("t1_frame_done", 32'(fd_cnt), 32'd1);
    check("t1_busy_after", 32'(o_busy), 32'd0);

    // 2: overflow with consumer stalled
    pix_q.delete();
    i_pixel_ready = 1'b0;
    vsync_pulse();
    cam_line(12, 8'h20);
    check("t2_valid", 32'(o_pixel_valid), 32'd1);
    check("t2_overflow", 32'(o_overflow), 32'd1);
    check("t2_line_width", 32'(o_line_width), 32'd6);
    check("t2_head", 32'(o_pixel_data), 32'h2021);
    wait_clk(3);
    check("t2_head_stable", 32'(o_pixel_data), 32'h2021);
    i_clear = 1'b1;
    wait_clk(1);
    i_clear = 1'b0;
    check("t2_overflow_clr", 32'(o_overflow), 32'd0);
    i_pixel_ready = 1'b1;
    wait_clk(8);
    check("t2_npix", 32'(pix_q.size()), 32'd4);
    check("t2_px0", 32'(pix_q[0]), 32'h2021);
    check("t2_px1", 32'(pix_q[1]), 32'h2223);
    check("t2_px2", 32'(pix_q[2]), 32'h2425);
    check("t2_px3", 32'(pix_q[3]), 32'h2627);
    check("t2_drained", 32'(o_pixel_valid), 32'd0);

    // 3: odd byte count line, then clean pairing
    pix_q.delete();
    cam_line(5, 8'h30);
    check("t3_byte_error", 32'(o_byte_error), 32'd1);
    check("t3_line_width", 32'(o_line_width), 32'd2);
    cam_line(4, 8'h40);
    check("t3_npix", 32'(pix_q.size()), 32'd4);
    check("t3_px0", 32'(pix_q[0]), 32'h3031);
    check("t3_px1", 32'(pix_q[1]), 32'h3233);
    check("t3_px2", 32'(pix_q[2]), 32'h4041);
    check("t3_px3", 32'(pix_q[3]), 32'h4243);
    check("t3_line_count", 32'(o_line_count), 32'd3);
    i_clear = 1'b1;
    wait_clk(1);
    i_clear = 1'b0;
    check("t3_byte_error_clr", 32'(o_byte_error), 32'd0);

    // 4: enable dropped mid-frame
    pix_q.delete();
    i_enable = 1'b0;
    cam_line(4, 8'h50);
    check("t4_npix", 32'(pix_q.size()), 32'd2);
    fd0 = fd_cnt;
    vsync_pulse();
    check("t4_frame_done", 32'(fd_cnt), 32'(fd0 + 1));
    check("t4_busy", 32'(o_busy), 32'd0);
    check("t4_line_count", 32'(o_line_count), 32'd4);
    pix_q.delete();
    vsync_pulse();
    cam_line(4, 8'h58);
    check("t4_ignored_npix", 32'(pix_q.size()), 32'd0);
    check("t4_ignored_valid", 32'(o_pixel_valid), 32'd0);
    check("t4_ignored_busy", 32'(o_busy), 32'd0);

    // 5: reset in the middle of a line
    i_enable = 1'b1;
    i_pixel_ready = 1'b0;
    wait_clk(2);
    vsync_pulse();
    i_cam_href = 1'b1;
    wait_clk(2);
    for (int i = 0; i < 4; i++) cam_byte(8'h70 + 8'(i));
    wait_clk(4);
    check("t5_pre_valid", 32'(o_pixel_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_valid", 32'(o_pixel_valid), 32'd0);
    check("t5_line_count", 32'(o_line_count), 32'd0);
    check("t5_line_width", 32'(o_line_width), 32'd0);
    check("t5_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    i_cam_href = 1'b0;
    i_cam_pclk = 1'b0;
    rst = 1'b1;
    wait_clk(4);
    check("t5_busy_after", 32'(o_busy), 32'd0);

    // 6: pin-to-valid latency
    vsync_pulse();
    i_cam_href = 1'b1;
    i_cam_pclk = 1'b0;
    wait_clk(2);
    cam_byte(8'h61);
    i_cam_data = 8'h62;
    i_cam_pclk = 1'b0;
    wait_clk(2);
    i_cam_pclk = 1'b1;
    wait_clk(4);
    check("t6_valid_4clk", 32'(o_pixel_valid), 32'd0);
    wait_clk(1);
    check("t6_valid_5clk", 32'(o_pixel_valid), 32'd1);
    check("t6_data", 32'(o_pixel_data), 32'h6162);
    i_cam_pclk = 1'b0;
    i_cam_href = 1'b0;
    wait_clk(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
